arm_hazard_scoreboard: RTL and testbench

Parametrised hazard-detection and forwarding controller for the ARM pipeline. It replaces the fixed hazard and forwarding pair with a single unit that tracks every in-flight register write in a DEPTH-entry shadow pipeline. From that state it generates the ID-stage stall, the EXE-stage operand forward selects and performance counters. Forwarding is runtime-selectable, and a memory-wait input freezes the tracked pipeline.

---
 rtl/arm_hazard_scoreboard.sv | 139 +++++++++++++
 tb/tb_arm_hazard_scoreboard.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_hazard_scoreboard.sv
// Purpose: tracks in-flight register writes and derives the ID stall, the EXE forward selects and stall/wait counters.
// Latency: hazard and sel_* are combinational (zero cycles) from inputs and state; state and counters update on the clk rising edge.
// Backpressure: hazard holds IF/ID and injects a bubble; mem_wait freezes every tracked entry and forces hazard high.
module arm_hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int REG_W = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             flush,
    input  logic             mem_wait,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    output logic             hazard,
    output logic [SEL_W-1:0] sel_src1,
    output logic [SEL_W-1:0] sel_src2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    // One shadow entry per tracked stage: index 0 is EXE, 1 is MEM, 2 is WB, ...
    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             load;
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic             two_src;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t ent [DEPTH];
    entry_t id_entry;
    logic   dh;
    logic   issue;

    // A tracked instruction produces register s.
    function automatic logic produces(input entry_t e, input logic [REG_W-1:0] s);
        return e.valid & e.wb_en & (e.dest == s);
    endfunction

    // An entry may feed EXE: a load still in MEM has no data yet, so it is skipped.
    function automatic logic fwd_ok(input entry_t e, input logic in_mem, input logic [REG_W-1:0] s);
        return produces(e, s) & ~(in_mem & e.load);
    endfunction

    // Data hazard for the ID instruction; forwarding mode only stalls on load-use.
    always_comb begin
        dh = 1'b0;
        if (id_valid) begin
            if (fwd_en) begin
                dh = ent[0].load & (produces(ent[0], id_src1) |
                                    (id_two_src & produces(ent[0], id_src2)));
            end else begin
                // The WB stage is excluded: the register file writes before the ID read.
                for (int k = 0; k < DEPTH - 1; k++) begin
                    if (produces(ent[k], id_src1) || (id_two_src && produces(ent[k], id_src2))) begin
                        dh = 1'b1;
                    end
                end
            end
        end
    end

    // Flush cancels a data stall (the ID instruction is dead); mem_wait always stalls.
    assign hazard = (dh & ~flush) | mem_wait;
    assign issue  = id_valid & ~hazard & ~flush;

    // Fields entering EXE on the next advance; valid carries whether it really issued.
    always_comb begin
        id_entry         = '0;
        id_entry.valid   = issue;
        id_entry.wb_en   = id_wb_en;
        id_entry.load    = id_mem_r_en;
        id_entry.dest    = id_dest;
        id_entry.src1    = id_src1;
        id_entry.src2    = id_src2;
        id_entry.two_src = id_two_src;
    end

    // Forward selects for the instruction in EXE; scanning oldest to youngest lets the nearest producer win.
    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        if (fwd_en && ent[0].valid) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (fwd_ok(ent[k], k == 1, ent[0].src1)) begin
                    sel_src1 = SEL_W'(k);
                end
                if (ent[0].two_src && fwd_ok(ent[k], k == 1, ent[0].src2)) begin
                    sel_src2 = SEL_W'(k);
                end
            end
        end
    end

    // Shadow pipeline: shift on advance, hold everything while memory waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent[k] <= '0;
            end
        end else if (!mem_wait) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                ent[k] <= ent[k-1];
            end
            ent[0] <= id_entry;
        end
    end

    // Saturating count of cycles stalled purely by a data dependency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (dh && !flush && !mem_wait && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Saturating count of memory-wait cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (mem_wait && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// Purpose: self-checking bench for arm_hazard_scoreboard (directed table plus random against a reference model).
// Latency: compares zero-cycle outputs mid-cycle, advances the model on each rising edge.
// Backpressure: drives mem_wait/flush directly; a second instance with 4-bit counters shows saturation.
module tb_arm_hazard_scoreboard;

    localparam int DEPTH = 3;
    localparam int REG_W = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 16;
    localparam int CNT_S = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fwd_en = 1'b0;
    logic             flush = 1'b0;
    logic             mem_wait = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_src1 = '0;
    logic [REG_W-1:0] id_src2 = '0;
    logic             id_two_src = 1'b0;
    logic [REG_W-1:0] id_dest = '0;
    logic             id_wb_en = 1'b0;
    logic             id_mem_r_en = 1'b0;

    logic             hazard, hazard_s;
    logic [SEL_W-1:0] sel_src1, sel_src2, sel_src1_s, sel_src2_s;
    logic [CNT_W-1:0] stall_cnt, wait_cnt;
    logic [CNT_S-1:0] stall_cnt_s, wait_cnt_s;

    arm_hazard_scoreboard #(.DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .mem_wait(mem_wait),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .hazard(hazard), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .stall_cnt(stall_cnt), .wait_cnt(wait_cnt)
    );

    arm_hazard_scoreboard #(.DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W), .CNT_W(CNT_S)) dut_s (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .mem_wait(mem_wait),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .hazard(hazard_s), .sel_src1(sel_src1_s), .sel_src2(sel_src2_s),
        .stall_cnt(stall_cnt_s), .wait_cnt(wait_cnt_s)
    );

    always #5 clk = ~clk;

    // One stimulus row: inputs and, for directed rows, the expected zero-cycle outputs.
    typedef struct {
        bit fwd, fl, mw, vld;
        int s1, s2;
        bit two;
        int dst;
        bit wb, ld;
        int haz, sel1, sel2;
    } vec_t;

    // Reference model: an in-order list of tracked instructions, youngest first.
    typedef struct {
        bit v, wb, ld, two;
        int dst, s1, s2;
    } instr_t;

    instr_t mq[$];
    longint m_stall, m_wait;
    int     checks = 0;
    int     errors = 0;
    vec_t   tab[$];

    function automatic vec_t mk(bit fwd, bit fl, bit mw, bit vld, int s1, int s2, bit two,
                                int dst, bit wb, bit ld, int haz, int sel1, int sel2);
        vec_t v;
        v.fwd = fwd; v.fl = fl; v.mw = mw; v.vld = vld; v.s1 = s1; v.s2 = s2; v.two = two;
        v.dst = dst; v.wb = wb; v.ld = ld; v.haz = haz; v.sel1 = sel1; v.sel2 = sel2;
        return v;
    endfunction

    function automatic bit writes(instr_t e, int r);
        return e.v && e.wb && (e.dst == r);
    endfunction

    function automatic bit reads(instr_t e, int r);
        return (e.s1 == r) || (e.two && e.s2 == r);
    endfunction

    // Does the ID instruction depend on a producer that cannot supply it in time?
    function automatic bit model_dh();
        instr_t idi;
        if (!id_valid) return 1'b0;
        idi.s1 = int'(id_src1); idi.s2 = int'(id_src2); idi.two = id_two_src;
        idi.v = 1'b1; idi.wb = 1'b0; idi.ld = 1'b0; idi.dst = 0;
        if (fwd_en) begin
            // Only a load one stage ahead is too late to forward.
            return mq[0].v && mq[0].wb && mq[0].ld &&
                   (reads(idi, mq[0].dst));
        end
        foreach (mq[k]) begin
            if (k < DEPTH - 1 && mq[k].v && mq[k].wb && reads(idi, mq[k].dst)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_haz();
        return (model_dh() && !flush) || mem_wait;
    endfunction

    // Youngest producer of r among stages 1.., skipping a load whose data is not back yet.
    function automatic int model_sel(int r, bit used);
        if (!fwd_en || !mq[0].v || !used) return 0;
        for (int k = 1; k < DEPTH; k++) begin
            if (writes(mq[k], r) && !(k == 1 && mq[k].ld)) return k;
        end
        return 0;
    endfunction

    function automatic longint sat(longint c, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_clear();
        instr_t z;
        z = '{v: 1'b0, wb: 1'b0, ld: 1'b0, two: 1'b0, dst: 0, s1: 0, s2: 0};
        mq.delete();
        for (int k = 0; k < DEPTH; k++) mq.push_back(z);
        m_stall = 0;
        m_wait  = 0;
    endtask

    // Model update for one rising edge, using the inputs currently applied.
    task automatic model_step();
        instr_t ni;
        bit     dh, haz;
        dh  = model_dh();
        haz = (dh && !flush) || mem_wait;
        if (dh && !flush && !mem_wait) m_stall++;
        if (mem_wait) m_wait++;
        if (!mem_wait) begin
            ni.v   = id_valid && !haz && !flush;
            ni.wb  = id_wb_en;
            ni.ld  = id_mem_r_en;
            ni.two = id_two_src;
            ni.dst = int'(id_dest);
            ni.s1  = int'(id_src1);
            ni.s2  = int'(id_src2);
            mq.push_front(ni);
            void'(mq.pop_back());
        end
    endtask

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_counters(string tag);
        chk({tag, " stall_cnt"}, longint'(stall_cnt), sat(m_stall, CNT_W));
        chk({tag, " wait_cnt"}, longint'(wait_cnt), sat(m_wait, CNT_W));
        chk({tag, " stall_cnt_s"}, longint'(stall_cnt_s), sat(m_stall, CNT_S));
        chk({tag, " wait_cnt_s"}, longint'(wait_cnt_s), sat(m_wait, CNT_S));
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic do_cycle(input vec_t v, input bit use_tab, input string tag);
        int eh, e1, e2;
        fwd_en      = v.fwd;
        flush       = v.fl;
        mem_wait    = v.mw;
        id_valid    = v.vld;
        id_src1     = REG_W'(v.s1);
        id_src2     = REG_W'(v.s2);
        id_two_src  = v.two;
        id_dest     = REG_W'(v.dst);
        id_wb_en    = v.wb;
        id_mem_r_en = v.ld;
        @(negedge clk);
        if (use_tab) begin
            eh = v.haz; e1 = v.sel1; e2 = v.sel2;
        end else begin
            eh = int'(model_haz());
            e1 = model_sel(int'(id_src1 == id_src1 ? mq[0].s1 : 0), 1'b1);
            e2 = model_sel(mq[0].s2, mq[0].two);
        end
        chk({tag, " hazard"}, longint'(hazard), longint'(eh));
        chk({tag, " sel_src1"}, longint'(sel_src1), longint'(e1));
        chk({tag, " sel_src2"}, longint'(sel_src2), longint'(e2));
        chk({tag, " hazard_s"}, longint'(hazard_s), longint'(eh));
        chk({tag, " sel_src1_s"}, longint'(sel_src1_s), longint'(e1));
        chk({tag, " sel_src2_s"}, longint'(sel_src2_s), longint'(e2));
        chk_counters(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock.
    task automatic do_reset();
        flush = 1'b0; mem_wait = 1'b0; id_valid = 1'b0;
        id_two_src = 1'b0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst hazard", longint'(hazard), 0);
        chk("rst sel_src1", longint'(sel_src1), 0);
        chk("rst sel_src2", longint'(sel_src2), 0);
        chk("rst stall_cnt", longint'(stall_cnt), 0);
        chk("rst wait_cnt", longint'(wait_cnt), 0);
        chk("rst stall_cnt_s", longint'(stall_cnt_s), 0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_tab(string name);
        foreach (tab[i]) do_cycle(tab[i], 1'b1, $sformatf("%s[%0d]", name, i));
        tab.delete();
    endtask

    initial begin
        vec_t v;
        bit   cur_fwd;
        model_clear();
        #6;
        do_reset();

        // Forwarding from MEM (back-to-back), then from WB (one-instruction gap).
        tab.push_back(mk(1,0,0,1, 2,3,1, 1,1,0, 0,0,0));
        tab.push_back(mk(1,0,0,1, 1,3,1, 2,1,0, 0,0,0));
        tab.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 0,1,0));
        tab.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 0,0,0));
        tab.push_back(mk(1,0,0,1, 2,3,1, 1,1,0, 0,0,0));
        tab.push_back(mk(1,0,0,1, 5,6,0, 7,0,0, 0,0,0));
        tab.push_back(mk(1,0,0,1, 1,3,1, 2,1,0, 0,0,0));
        tab.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 0,2,0));
        run_tab("fwd");
        do_reset();

        // Load-use: one stall, then both operands from WB.
        tab.push_back(mk(1,0,0,1, 0,0,0, 4,1,1, 0,0,0));
        tab.push_back(mk(1,0,0,1, 4,4,1, 5,1,0, 1,0,0));
        tab.push_back(mk(1,0,0,1, 4,4,1, 5,1,0, 0,0,0));
        tab.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 0,2,2));
        run_tab("ldu");
        chk("ldu stall_cnt const", longint'(stall_cnt), 1);
        do_reset();

        // Stall-only: DEPTH-1 stall cycles on an EXE producer, selects stay 0.
        tab.push_back(mk(0,0,0,1, 2,3,1, 1,1,0, 0,0,0));
        tab.push_back(mk(0,0,0,1, 1,0,0, 2,1,0, 1,0,0));
        tab.push_back(mk(0,0,0,1, 1,0,0, 2,1,0, 1,0,0));
        tab.push_back(mk(0,0,0,1, 1,0,0, 2,1,0, 0,0,0));
        tab.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0));
        run_tab("stl");
        chk("stl stall_cnt const", longint'(stall_cnt), 2);
        do_reset();

        // Flush over a load-use, then five frozen cycles (one with flush) holding sel at 2.
        tab.push_back(mk(1,0,0,1, 0,0,0, 4,1,1, 0,0,0));
        tab.push_back(mk(1,1,0,1, 4,0,0, 5,1,0, 0,0,0));
        tab.push_back(mk(1,0,0,1, 4,0,0, 6,1,0, 0,0,0));
        tab.push_back(mk(1,1,1,1, 6,0,0, 7,1,0, 1,2,0));
        for (int i = 0; i < 4; i++) tab.push_back(mk(1,0,1,1, 6,0,0, 7,1,0, 1,2,0));
        tab.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 0,2,0));
        run_tab("flw");
        chk("flw wait_cnt const", longint'(wait_cnt), 5);
        chk("flw stall_cnt const", longint'(stall_cnt), 0);

        // Reset with a populated pipe; the next instruction issues and is tracked.
        do_reset();
        tab.push_back(mk(0,0,0,1, 4,0,0, 9,1,0, 0,0,0));
        tab.push_back(mk(0,0,0,1, 9,0,0, 10,1,0, 1,0,0));
        run_tab("rmo");
        do_reset();

        // Ten stall-only dependencies: 20 stall cycles, 4-bit counter stops at 15.
        for (int n = 0; n < 10; n++) begin
            do_cycle(mk(0,0,0,1, 5,6,1, 1,1,0, 0,0,0), 1'b0, "sat");
            for (int j = 0; j < 3; j++) do_cycle(mk(0,0,0,1, 1,0,0, 2,1,0, 0,0,0), 1'b0, "sat");
        end
        chk("sat stall_cnt const", longint'(stall_cnt), 20);
        chk("sat stall_cnt_s const", longint'(stall_cnt_s), 15);
        do_reset();

        // Random traffic on a small register set against the model.
        cur_fwd = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) cur_fwd = !cur_fwd;
            if ($urandom_range(0, 599) == 0) do_reset();
            v = mk(cur_fwd, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 4) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, 0, 0, 0);
            do_cycle(v, 1'b0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
